btn_debounce_oneshot: RTL

Conditions a raw, asynchronous push-button input into a clean debounced level and a fixed-width one-shot load pulse. It sits directly upstream of a DReg: `pulse` drives the register's `ld`, so each physical press loads `dIn` exactly once. It also supplies a debounced level for status display and an optional press counter.

---
 rtl/db_pkg.sv | 17 +
 rtl/sync2.sv | 21 ++
 rtl/btn_debounce_oneshot.sv | 121 ++++++++++++
 3 files changed

// File: rtl/db_pkg.sv
// Shared types and default parameters for the push-button debouncer.
package db_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_HI = 3'd1,
        PULSE   = 3'd2,
        HOLD    = 3'd3,
        WAIT_LO = 3'd4
    } db_state_t;

    localparam int DEF_CNT_WIDTH    = 20;
    localparam int DEF_DB_CYCLES    = 500000;
    localparam int DEF_PULSE_CYCLES = 1;
    localparam int PCNT_WIDTH       = 4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous external inputs; synchronous active-high reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debounce_oneshot.sv
// Push-button debouncer with a fixed-width one-shot load pulse and debounced level.
// Define DB_PRESS_CNT_EN to build the 8-bit accepted-press counter; otherwise press_cnt is tied to 0.
//
// state   | meaning
// IDLE    | button released and stable, db=0
// WAIT_HI | button seen high, counting stable-high samples, db=0
// PULSE   | press accepted, one-shot active, db=1
// HOLD    | button held and stable, db=1
// WAIT_LO | button seen low, counting stable-low samples, db=1
module btn_debounce_oneshot
    import db_pkg::*;
#(
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter int DB_CYCLES    = DEF_DB_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic       db,
    output logic       pulse,
    output logic [7:0] press_cnt
);

    localparam logic [CNT_WIDTH-1:0]  DB_LAST = CNT_WIDTH'(DB_CYCLES - 1);
    localparam logic [PCNT_WIDTH-1:0] P_LAST  = PCNT_WIDTH'(PULSE_CYCLES - 1);

    db_state_t             state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [PCNT_WIDTH-1:0] pcnt;
    logic                  btn_s;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn),
        .q   (btn_s)
    );

    // db and pulse are registered together with the state so they never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            pcnt  <= '0;
            db    <= 1'b0;
            pulse <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= WAIT_HI;
                        cnt   <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (cnt == DB_LAST) begin
                        state <= PULSE;
                        pcnt  <= '0;
                        db    <= 1'b1;
                        pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PULSE: begin
                    // Pulse width is fixed; a release here is picked up later in HOLD.
                    if (pcnt == P_LAST) begin
                        state <= HOLD;
                        pulse <= 1'b0;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!btn_s) begin
                        state <= WAIT_LO;
                        cnt   <= '0;
                    end
                end
                WAIT_LO: begin
                    if (btn_s) begin
                        state <= HOLD;
                    end else if (cnt == DB_LAST) begin
                        state <= IDLE;
                        db    <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    db    <= 1'b0;
                    pulse <= 1'b0;
                end
            endcase
        end
    end

`ifdef DB_PRESS_CNT_EN
    logic [7:0] press_q;
    logic       press_fire;

    assign press_fire = (state == WAIT_HI) && btn_s && (cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            press_q <= 8'h00;
        end else if (press_fire) begin
            press_q <= press_q + 8'd1;
        end
    end

    assign press_cnt = press_q;
`else
    assign press_cnt = 8'h00;
`endif

endmodule
